// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding, scoreboard slot width and ID/EX bubble controls
package hazard_pkg;
  typedef enum logic [1:0] {RUN = 2'b00, DRAIN = 2'b01, HALTED = 2'b10} state_t;
  localparam int SLOT_W = 4;
  typedef struct packed {
    logic reg_wr_en;
    logic mem_en;
    logic mem_wr;
    logic dump;
    logic jump;
    logic branch;
  } idex_ctrl_t;
  localparam idex_ctrl_t BUBBLE_CTRL = '0;
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: EX/MEM in-flight writer slots with hold, kill and source match
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  input  logic       kill,
  input  logic       wr_valid,
  input  logic [2:0] wr_dst,
  input  logic [2:0] rs,
  input  logic [2:0] rt,
  output logic       match_rs,
  output logic       match_rt
);
  logic [SLOT_W-1:0] ex, mem;
  always_ff @(posedge clk) begin
    if (rst) begin
      ex  <= '0;
      mem <= '0;
    end else if (!hold) begin
      mem <= ex;
      ex  <= kill ? '0 : {wr_valid, wr_dst};
    end
  end
  always_comb begin
    match_rs = (ex[SLOT_W-1] && ex[2:0] == rs) || (mem[SLOT_W-1] && mem[2:0] == rs);
    match_rt = (ex[SLOT_W-1] && ex[2:0] == rt) || (mem[SLOT_W-1] && mem[2:0] == rt);
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage RAW stall, flush, bubble and dump-drain control
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic [2:0]       dec_rs,
  input  logic [2:0]       dec_rt,
  input  logic             dec_rs_used,
  input  logic             dec_rt_used,
  input  logic [2:0]       dec_dst,
  input  logic             dec_wr_en,
  input  logic             dec_dump,
  input  logic             ex_flush,
  input  logic             mem_stall,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             halt_out,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  state_t        state;
  logic [DW-1:0] drain_cnt;
  logic          match_rs, match_rt, hazard, run, drn, stall_inc, issue;
  hazard_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .hold     (mem_stall || state == HALTED),
    .kill     (idex_bubble),
    .wr_valid (dec_valid && dec_wr_en),
    .wr_dst   (dec_dst),
    .rs       (dec_rs),
    .rt       (dec_rt),
    .match_rs (match_rs),
    .match_rt (match_rt)
  );
  always_comb begin
    run         = state == RUN;
    drn         = state == DRAIN;
    hazard      = dec_valid && ((dec_rs_used && match_rs) || (dec_rt_used && match_rt));
    stall_inc   = run && !mem_stall && !ex_flush && hazard;
    issue       = run && !mem_stall && !ex_flush && !hazard;
    pc_en       = run && !mem_stall && (ex_flush || !hazard);
    ifid_en     = pc_en;
    ifid_flush  = run && !mem_stall && ex_flush;
    idex_en     = (run || drn) && !mem_stall;
    idex_bubble = drn || (run && !mem_stall && (ex_flush || hazard));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      drain_cnt    <= '0;
      halt_out     <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (stall_inc && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
      case (state)
        RUN: if (issue && dec_valid && dec_dump) begin
          state     <= DRAIN;
          drain_cnt <= '0;
        end
        DRAIN: if (!mem_stall) begin
          drain_cnt <= drain_cnt + DW'(1);
          if (drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
            state    <= HALTED;
            halt_out <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector table, corner sequences and randomized model check
module tb_hazard_ctrl;
  localparam int DC = 3;
  logic clk = 1'b0, rst;
  logic dec_valid, dec_rs_used, dec_rt_used, dec_wr_en, dec_dump, ex_flush, mem_stall;
  logic [2:0] dec_rs, dec_rt, dec_dst;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, halt_out;
  logic [15:0] stall_cycles;
  int checks = 0, errors = 0;
  int mode = 0, dleft = 0, exw = -1, memw = -1, msc = 0;

  typedef struct packed {
    logic r, v;
    logic [2:0] rs, rt;
    logic rsu, rtu;
    logic [2:0] dst;
    logic we, dump, fl, ms;
  } in_t;
  typedef struct {
    in_t i;
    logic [4:0] o;
    logic [15:0] sc;
  } vec_t;

  hazard_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_rs_used(dec_rs_used), .dec_rt_used(dec_rt_used), .dec_dst(dec_dst),
    .dec_wr_en(dec_wr_en), .dec_dump(dec_dump), .ex_flush(ex_flush), .mem_stall(mem_stall),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_bubble(idex_bubble), .halt_out(halt_out), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic in_t ins(logic r, logic v, logic [2:0] rs, logic [2:0] rt, logic rsu,
                              logic rtu, logic [2:0] dst, logic we, logic dump, logic fl, logic ms);
    ins = '{r, v, rs, rt, rsu, rtu, dst, we, dump, fl, ms};
  endfunction

  function automatic logic reads(logic [2:0] r);
    reads = int'(r) == exw || int'(r) == memw;
  endfunction

  function automatic logic hzf(in_t i);
    hzf = i.v && ((i.rsu && reads(i.rs)) || (i.rtu && reads(i.rt)));
  endfunction

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble}
  function automatic logic [4:0] mexp(in_t i);
    if (mode == 0) mexp = i.ms ? 5'b00000 : i.fl ? 5'b11111 : hzf(i) ? 5'b00011 : 5'b11010;
    else if (mode == 1) mexp = i.ms ? 5'b00001 : 5'b00011;
    else mexp = 5'b00000;
  endfunction

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask

  task automatic step(input in_t i, input string n, output logic [4:0] ao,
                      output logic ah, output logic [15:0] asc);
    logic [4:0] eo;
    logic hz;
    rst = i.r; dec_valid = i.v; dec_rs = i.rs; dec_rt = i.rt; dec_rs_used = i.rsu;
    dec_rt_used = i.rtu; dec_dst = i.dst; dec_wr_en = i.we; dec_dump = i.dump;
    ex_flush = i.fl; mem_stall = i.ms;
    @(negedge clk);
    ao = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble};
    ah = halt_out;
    asc = stall_cycles;
    eo = mexp(i);
    hz = hzf(i);
    chk({n, " out"}, 16'(ao), 16'(eo));
    chk({n, " halt"}, 16'(ah), 16'(mode == 2));
    chk({n, " cnt"}, asc, 16'(msc));
    if (i.r) begin
      mode = 0; dleft = 0; exw = -1; memw = -1; msc = 0;
    end else begin
      if (mode != 2 && !i.ms) begin
        memw = exw;
        exw = eo[0] ? -1 : (i.v && i.we) ? int'(i.dst) : -1;
      end
      if (mode == 0 && !i.ms && !i.fl) begin
        if (hz) msc = (msc < 65535) ? msc + 1 : msc;
        else if (i.v && i.dump) begin mode = 1; dleft = DC; end
      end else if (mode == 1 && !i.ms) begin
        dleft--;
        if (dleft == 0) mode = 2;
      end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t t[15];
  logic [4:0] ao;
  logic ah;
  logic [15:0] asc;
  in_t rd, rnd;

  initial begin
    t[0]  = '{ins(0,1,0,0,0,0,3,1,0,0,0), 5'b11010, 16'd0};
    t[1]  = '{ins(0,1,3,0,1,0,6,1,0,0,0), 5'b00011, 16'd0};
    t[2]  = '{ins(0,1,3,0,1,0,6,1,0,0,0), 5'b00011, 16'd1};
    t[3]  = '{ins(0,1,3,0,1,0,6,1,0,0,0), 5'b11010, 16'd2};
    t[4]  = '{ins(0,1,0,1,0,1,3,1,0,0,0), 5'b11010, 16'd2};
    t[5]  = '{ins(0,1,4,5,1,1,0,0,0,0,0), 5'b11010, 16'd2};
    t[6]  = '{ins(0,0,0,0,0,0,0,0,0,0,0), 5'b11010, 16'd2};
    t[7]  = '{ins(0,1,0,0,0,0,2,1,0,0,0), 5'b11010, 16'd2};
    t[8]  = '{ins(0,1,2,0,1,0,0,0,0,1,0), 5'b11111, 16'd2};
    t[9]  = '{ins(0,1,2,0,1,0,0,0,0,0,0), 5'b00011, 16'd2};
    t[10] = '{ins(0,0,0,0,0,0,0,0,0,0,0), 5'b11010, 16'd3};
    t[11] = '{ins(0,1,0,0,0,0,0,1,0,0,0), 5'b11010, 16'd3};
    t[12] = '{ins(0,1,0,0,0,1,0,0,0,0,0), 5'b00011, 16'd3};
    t[13] = '{ins(0,1,0,0,0,1,0,0,0,0,0), 5'b00011, 16'd4};
    t[14] = '{ins(0,0,0,0,0,0,0,0,0,0,0), 5'b11010, 16'd5};
    rst = 1'b1; dec_valid = 0; dec_rs = 0; dec_rt = 0; dec_rs_used = 0; dec_rt_used = 0;
    dec_dst = 0; dec_wr_en = 0; dec_dump = 0; ex_flush = 0; mem_stall = 0;
    @(posedge clk);
    #1;
    step(ins(0,0,0,0,0,0,0,0,0,0,0), "reset", ao, ah, asc);
    chk("reset out const", 16'(ao), 16'(5'b11010));
    chk("reset halt const", 16'(ah), 16'd0);
    for (int k = 0; k < 15; k++) begin
      step(t[k].i, $sformatf("vec%0d", k), ao, ah, asc);
      chk($sformatf("vec%0d tbl out", k), 16'(ao), 16'(t[k].o));
      chk($sformatf("vec%0d tbl cnt", k), asc, t[k].sc);
    end
    // memory stall in the middle of a hazard
    rd = ins(0,1,5,0,1,0,0,0,0,0,0);
    step(ins(0,1,0,0,0,0,5,1,0,0,0), "ms wr", ao, ah, asc);
    step(rd, "ms hz1", ao, ah, asc);
    chk("ms hz1 const", 16'(ao), 16'(5'b00011));
    rd.ms = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(rd, "ms hold", ao, ah, asc);
      chk("ms hold const", 16'(ao), 16'(5'b00000));
    end
    rd.ms = 1'b0;
    step(rd, "ms hz2", ao, ah, asc);
    chk("ms hz2 const", 16'(ao), 16'(5'b00011));
    step(rd, "ms issue", ao, ah, asc);
    chk("ms issue const", 16'(ao), 16'(5'b11010));
    chk("ms cnt const", asc, 16'd7);
    // dump drain with an ignored flush and a stalled edge
    step(ins(0,1,0,0,0,0,0,0,1,0,0), "dump cap", ao, ah, asc);
    step(ins(0,0,0,0,0,0,0,0,0,1,0), "drain fl", ao, ah, asc);
    chk("drain fl const", 16'(ao), 16'(5'b00011));
    step(ins(0,0,0,0,0,0,0,0,0,0,1), "drain ms", ao, ah, asc);
    step(ins(0,0,0,0,0,0,0,0,0,0,0), "drain 2", ao, ah, asc);
    step(ins(0,0,0,0,0,0,0,0,0,0,0), "drain 3", ao, ah, asc);
    chk("drain 3 halt const", 16'(ah), 16'd0);
    step(ins(0,1,0,0,0,0,1,1,0,0,0), "halted", ao, ah, asc);
    chk("halted out const", 16'(ao), 16'(5'b00000));
    chk("halted halt const", 16'(ah), 16'd1);
    step(ins(1,0,0,0,0,0,0,0,0,0,0), "halt rst", ao, ah, asc);
    step(ins(0,0,0,0,0,0,0,0,0,0,0), "after rst", ao, ah, asc);
    chk("after rst const", 16'(ao), 16'(5'b11010));
    // counter saturation
    force dut.stall_cycles = 16'hFFFE;
    #1;
    release dut.stall_cycles;
    msc = 65534;
    for (int r = 0; r < 2; r++) begin
      step(ins(0,1,0,0,0,0,1,1,0,0,0), "sat wr", ao, ah, asc);
      for (int k = 0; k < 3; k++) step(ins(0,1,1,0,1,0,0,0,0,0,0), "sat rd", ao, ah, asc);
      chk("sat const", asc, 16'hFFFF);
    end
    step(ins(1,0,0,0,0,0,0,0,0,0,0), "rnd rst", ao, ah, asc);
    for (int k = 0; k < 3000; k++) begin
      rnd.r    = (mode == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0;
      rnd.v    = $urandom_range(0, 3) != 0;
      rnd.rs   = 3'($urandom_range(0, 3));
      rnd.rt   = 3'($urandom_range(0, 7));
      rnd.rsu  = $urandom_range(0, 1) == 1;
      rnd.rtu  = $urandom_range(0, 1) == 1;
      rnd.dst  = 3'($urandom_range(0, 3));
      rnd.we   = $urandom_range(0, 3) != 0;
      rnd.dump = $urandom_range(0, 59) == 0;
      rnd.fl   = $urandom_range(0, 7) == 0;
      rnd.ms   = $urandom_range(0, 5) == 0;
      step(rnd, "rnd", ao, ah, asc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
